flow_led_seq: RTL and testbench



---
 rtl/flow_led_seq_if.sv | 23 ++
 rtl/flow_led_seq.sv | 114 +++++++++++
 tb/tb_flow_led_seq.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/flow_led_seq_if.sv
// Bundle of the pattern sequencer's control inputs and LED/debug outputs.
// The master side drives the upstream tick level and the controls; the
// slave side is the sequencer itself.
interface flow_led_seq_if #(
  parameter int N_LED = 4
);
  logic             tick_in;
  logic             en;
  logic [1:0]       mode;
  logic [N_LED-1:0] led_out;
  logic             step_pulse;
  logic             dir;

  modport master (
    output tick_in, en, mode,
    input  led_out, step_pulse, dir
  );

  modport slave (
    input  tick_in, en, mode,
    output led_out, step_pulse, dir
  );
endinterface

// File: rtl/flow_led_seq.sv
// Flowing one-hot LED sequencer driven by rising edges of an upstream blink
// level. Supports rotate left, rotate right, ping-pong and hold, with an
// optional divider between qualified edges and pattern advances. All outputs
// come straight from registers.
module flow_led_seq #(
  parameter int N_LED    = 4,
  parameter int STEP_DIV = 1,
  parameter int DIV_W    = 8
) (
  input  logic          CLK,
  input  logic          RST,
  flow_led_seq_if.slave bus
);

  typedef enum logic {
    LEFT  = 1'b0,
    RIGHT = 1'b1
  } dir_e;

  localparam logic [1:0] MODE_LEFT  = 2'b00;
  localparam logic [1:0] MODE_RIGHT = 2'b01;
  localparam logic [1:0] MODE_PING  = 2'b10;
  localparam logic [1:0] MODE_HOLD  = 2'b11;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);

  logic             tick_d;
  logic [DIV_W-1:0] div_cnt, div_nxt;
  logic [N_LED-1:0] led_q, led_nxt;
  dir_e             dir_q, dir_nxt;
  logic             step_q, step_nxt;

  logic             rise;
  logic             qual;
  logic [N_LED-1:0] led_rotl;
  logic [N_LED-1:0] led_rotr;

  assign rise     = bus.tick_in & ~tick_d;
  assign qual     = rise & bus.en & (bus.mode != MODE_HOLD);
  assign led_rotl = {led_q[N_LED-2:0], led_q[N_LED-1]};
  assign led_rotr = {led_q[0], led_q[N_LED-1:1]};

  // State register; tick_d resets high so a tick already high at release is not an edge.
  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tick_d  <= 1'b1;
      div_cnt <= '0;
      led_q   <= N_LED'(1);
      dir_q   <= LEFT;
      step_q  <= 1'b0;
    end else begin
      tick_d  <= bus.tick_in;
      div_cnt <= div_nxt;
      led_q   <= led_nxt;
      dir_q   <= dir_nxt;
      step_q  <= step_nxt;
    end
  end

  // Next-state logic: divider, pattern advance and ping-pong direction FSM.
  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    div_nxt  = div_cnt;
    led_nxt  = led_q;
    dir_nxt  = dir_q;
    step_nxt = 1'b0;

    if (qual) begin
      if (div_cnt == DIV_LAST) begin
        div_nxt  = '0;
        step_nxt = 1'b1;
        unique case (bus.mode)
          MODE_LEFT: begin
            led_nxt = led_rotl;
            dir_nxt = LEFT;
          end
          MODE_RIGHT: begin
            led_nxt = led_rotr;
            dir_nxt = RIGHT;
          end
          MODE_PING: begin
            // Turn around on the end LED and move in the same step (no double dwell).
            if (dir_q == LEFT) begin
              if (led_q[N_LED-1]) begin
                dir_nxt = RIGHT;
                led_nxt = led_rotr;
              end else begin
                led_nxt = led_rotl;
              end
            end else begin
              if (led_q[0]) begin
                dir_nxt = LEFT;
                led_nxt = led_rotl;
              end else begin
                led_nxt = led_rotr;
              end
            end
          end
          default: begin
            // Hold never qualifies an event; nothing to do.
          end
        endcase
      end else begin
        div_nxt = div_cnt + 1'b1;
      end
    end
  end

  assign bus.led_out    = led_q;
  assign bus.step_pulse = step_q;
  assign bus.dir        = dir_q;

endmodule

// File: tb/tb_flow_led_seq.sv
// Directed bench for flow_led_seq: one instance with STEP_DIV=1 and one with
// STEP_DIV=3 share clock, reset and the tick level; each has its own controls.
module tb_flow_led_seq;

  logic clk;
  logic rst;
  logic tick;

  int n_checks = 0;
  int n_fail   = 0;
  int pulses1  = 0;
  int pulses3  = 0;
  int base;

  flow_led_seq_if #(.N_LED(4)) if1 ();
  flow_led_seq_if #(.N_LED(4)) if3 ();

  assign if1.tick_in = tick;
  assign if3.tick_in = tick;

  flow_led_seq #(.N_LED(4), .STEP_DIV(1), .DIV_W(8)) u_dut1 (
    .CLK (clk),
    .RST (rst),
    .bus (if1)
  );

  flow_led_seq #(.N_LED(4), .STEP_DIV(3), .DIV_W(8)) u_dut3 (
    .CLK (clk),
    .RST (rst),
    .bus (if3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count high cycles of each step strobe, sampled mid-cycle.
  always @(negedge clk) begin
    if (if1.step_pulse) pulses1++;
    if (if3.step_pulse) pulses3++;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // One tick rise on the shared level, entered just after a posedge.
  // Checks the selected instance before the sampling edge, one cycle after
  // (new pattern, strobe) and two cycles after (strobe gone).
  task automatic rise(input bit inst3, input string tag, input logic [3:0] exp_prev,
                      input logic [3:0] exp_led, input logic exp_dir, input logic exp_step);
    tick = 1'b1;
    @(negedge clk);
    chk({tag, "_pre_led"}, inst3 ? if3.led_out : if1.led_out, exp_prev);
    chk({tag, "_pre_step"}, inst3 ? if3.step_pulse : if1.step_pulse, 1'b0);
    cycle();
    chk({tag, "_led"}, inst3 ? if3.led_out : if1.led_out, exp_led);
    chk({tag, "_dir"}, inst3 ? if3.dir : if1.dir, exp_dir);
    chk({tag, "_step"}, inst3 ? if3.step_pulse : if1.step_pulse, exp_step);
    cycle();
    chk({tag, "_step_end"}, inst3 ? if3.step_pulse : if1.step_pulse, 1'b0);
    tick = 1'b0;
    cycle();
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    cycle();
    rst = 1'b0;
    cycle();
  endtask

  initial begin
    rst      = 1'b1;
    tick     = 1'b1;
    if1.en   = 1'b1;
    if1.mode = 2'b00;
    if3.en   = 1'b0;
    if3.mode = 2'b00;

    // Reset with tick held high, then release and keep it high.
    repeat (3) cycle();
    chk("rst_led", if1.led_out, 4'b0001);
    chk("rst_step", if1.step_pulse, 1'b0);
    chk("rst_dir", if1.dir, 1'b0);
    base = pulses1;
    rst = 1'b0;
    repeat (10) cycle();
    chk("rel_led", if1.led_out, 4'b0001);
    chk("rel_dir", if1.dir, 1'b0);
    chk("rel_no_pulse", 16'(pulses1 - base), 16'd0);
    tick = 1'b0;
    cycle();

    // Rotate left, four advances with a wrap.
    base = pulses1;
    rise(0, "left1", 4'b0001, 4'b0010, 1'b0, 1'b1);
    rise(0, "left2", 4'b0010, 4'b0100, 1'b0, 1'b1);
    rise(0, "left3", 4'b0100, 4'b1000, 1'b0, 1'b1);
    rise(0, "left4", 4'b1000, 4'b0001, 1'b0, 1'b1);
    chk("left_pulses", 16'(pulses1 - base), 16'd4);

    // Rotate right from reset, then switch to left together with a rise.
    do_reset();
    if1.mode = 2'b01;
    rise(0, "right1", 4'b0001, 4'b1000, 1'b1, 1'b1);
    rise(0, "right2", 4'b1000, 4'b0100, 1'b1, 1'b1);
    if1.mode = 2'b00;
    rise(0, "sw_left", 4'b0100, 4'b1000, 1'b0, 1'b1);

    // Ping-pong from 0001 through both turnarounds.
    do_reset();
    if1.mode = 2'b10;
    rise(0, "pp1", 4'b0001, 4'b0010, 1'b0, 1'b1);
    rise(0, "pp2", 4'b0010, 4'b0100, 1'b0, 1'b1);
    rise(0, "pp3", 4'b0100, 4'b1000, 1'b0, 1'b1);
    rise(0, "pp4", 4'b1000, 4'b0100, 1'b1, 1'b1);
    rise(0, "pp5", 4'b0100, 4'b0010, 1'b1, 1'b1);
    rise(0, "pp6", 4'b0010, 4'b0001, 1'b1, 1'b1);
    rise(0, "pp7", 4'b0001, 4'b0010, 1'b0, 1'b1);

    // Divide by three with both freeze forms in between.
    if1.en   = 1'b0;
    if3.en   = 1'b1;
    if3.mode = 2'b00;
    rise(1, "div_a1", 4'b0001, 4'b0001, 1'b0, 1'b0);
    rise(1, "div_a2", 4'b0001, 4'b0001, 1'b0, 1'b0);
    if3.en = 1'b0;
    rise(1, "frz_en1", 4'b0001, 4'b0001, 1'b0, 1'b0);
    rise(1, "frz_en2", 4'b0001, 4'b0001, 1'b0, 1'b0);
    rise(1, "frz_en3", 4'b0001, 4'b0001, 1'b0, 1'b0);
    if3.en   = 1'b1;
    if3.mode = 2'b11;
    rise(1, "frz_hold1", 4'b0001, 4'b0001, 1'b0, 1'b0);
    rise(1, "frz_hold2", 4'b0001, 4'b0001, 1'b0, 1'b0);
    if3.mode = 2'b00;
    rise(1, "div_kept", 4'b0001, 4'b0010, 1'b0, 1'b1);
    rise(1, "div_b1", 4'b0010, 4'b0010, 1'b0, 1'b0);
    rise(1, "div_b2", 4'b0010, 4'b0010, 1'b0, 1'b0);
    rise(1, "div_b3", 4'b0010, 4'b0100, 1'b0, 1'b1);
    rise(1, "div_b4", 4'b0100, 4'b0100, 1'b0, 1'b0);
    rise(1, "div_b5", 4'b0100, 4'b0100, 1'b0, 1'b0);
    rise(1, "div_b6", 4'b0100, 4'b1000, 1'b0, 1'b1);

    // Asynchronous reset between edges while a strobe is high at 0100.
    if3.en   = 1'b0;
    if1.en   = 1'b1;
    if1.mode = 2'b00;
    tick = 1'b1;
    cycle();
    chk("mid_led_before", if1.led_out, 4'b0100);
    chk("mid_step_before", if1.step_pulse, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("mid_led_async", if1.led_out, 4'b0001);
    chk("mid_step_async", if1.step_pulse, 1'b0);
    chk("mid_dir_async", if1.dir, 1'b0);
    cycle();
    rst  = 1'b0;
    base = pulses1;
    repeat (4) cycle();
    chk("mid_no_false_edge", if1.led_out, 4'b0001);
    chk("mid_no_pulse", 16'(pulses1 - base), 16'd0);
    tick = 1'b0;
    cycle();
    rise(0, "post_rst", 4'b0001, 4'b0010, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
